m_seq_multiplier: RTL and testbench

- Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.
- Sits directly upstream of the 32-bit ripple adder m_adder and instantiates one copy internally, driving it with a new operand pair every cycle.
- Accepts an operation over a valid/ready handshake and returns the selected 32-bit half of the 64-bit product after a fixed latency.
- Holds the result until the consumer accepts it.

---
 rtl/m_seq_multiplier.sv | 182 ++++++++++++++++++
 tb/tb_m_seq_multiplier.sv | 136 +++++++++++++
 2 files changed

// File: rtl/m_seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One ripple adder does all arithmetic: the 32 accumulate steps plus a two-step sign fix-up.

module m_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_operand1_32,
  input  logic [XLEN-1:0] i_operand2_32,
  input  logic            i_cIn_1,
  output logic [XLEN-1:0] o_sum_32,
  output logic            o_cOut_1
);

  // The carry is a local variable so the ripple chain is not seen as a self-feeding vector.
  always_comb begin
    logic carry;
    carry    = i_cIn_1;
    o_sum_32 = '0;
    for (int i = 0; i < XLEN; i++) begin
      o_sum_32[i] = i_operand1_32[i] ^ i_operand2_32[i] ^ carry;
      carry       = (i_operand1_32[i] & i_operand2_32[i]) |
                    (carry & (i_operand1_32[i] ^ i_operand2_32[i]));
    end
    o_cOut_1 = carry;
  end

endmodule

module m_seq_multiplier #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            i_clk_1,
  input  logic            i_rst_1,
  input  logic            i_opValid_1,
  output logic            o_opReady_1,
  input  logic [1:0]      i_mulOp_2,
  input  logic [XLEN-1:0] i_operand1_32,
  input  logic [XLEN-1:0] i_operand2_32,
  output logic            o_resultValid_1,
  input  logic            i_resultReady_1,
  output logic [XLEN-1:0] o_result_32,
  output logic            o_busy_1
);

  typedef enum logic [2:0] {IDLE, CALC, NEG_LO, NEG_HI, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} op_t;

  state_t            state, state_nxt;
  op_t               op_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mcand;
  logic              neg;
  logic              carry_q;

  logic [XLEN-1:0]   add_a, add_b, add_sum;
  logic              add_cin, add_cout;

  logic              rs1_neg, rs2_neg;
  logic [XLEN-1:0]   rs1_abs, rs2_abs, hi_final;

  // Two's-complement negate without an adder: invert every bit above the lowest set bit.
  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    logic seen;
    seen   = 1'b0;
    negate = '0;
    for (int i = 0; i < XLEN; i++) begin
      negate[i] = x[i] ^ seen;
      seen      = seen | x[i];
    end
  endfunction

  function automatic logic [CNT_W-1:0] incr(input logic [CNT_W-1:0] x);
    logic c;
    c    = 1'b1;
    incr = '0;
    for (int i = 0; i < CNT_W; i++) begin
      incr[i] = x[i] ^ c;
      c       = c & x[i];
    end
  endfunction

  m_adder #(.XLEN(XLEN)) u_adder (
    .i_operand1_32 (add_a),
    .i_operand2_32 (add_b),
    .i_cIn_1       (add_cin),
    .o_sum_32      (add_sum),
    .o_cOut_1      (add_cout)
  );

  // MUL works on raw operands; only the high-word ops treat operands as signed.
  always_comb begin
    rs1_neg = ((i_mulOp_2 == OP_MULH) || (i_mulOp_2 == OP_MULHSU)) && i_operand1_32[XLEN-1];
    rs2_neg = (i_mulOp_2 == OP_MULH) && i_operand2_32[XLEN-1];
    rs1_abs = rs1_neg ? negate(i_operand1_32) : i_operand1_32;
    rs2_abs = rs2_neg ? negate(i_operand2_32) : i_operand2_32;
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      CALC: begin
        add_a = prod[2*XLEN-1:XLEN];
        add_b = prod[0] ? mcand : '0;
      end
      NEG_LO: begin
        add_a   = ~prod[XLEN-1:0];
        add_cin = 1'b1;
      end
      NEG_HI: begin
        add_a   = ~prod[2*XLEN-1:XLEN];
        add_cin = carry_q;
      end
      default: ;
    endcase
  end

  assign hi_final = neg ? add_sum : prod[2*XLEN-1:XLEN];

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_opValid_1) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(XLEN - 1)) state_nxt = NEG_LO;
      NEG_LO:  state_nxt = NEG_HI;
      NEG_HI:  state_nxt = DONE;
      DONE:    if (i_resultReady_1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk_1 or posedge i_rst_1) begin
    if (i_rst_1) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clk_1 or posedge i_rst_1) begin
    if (i_rst_1) begin
      op_q        <= OP_MUL;
      cnt         <= '0;
      prod        <= '0;
      mcand       <= '0;
      neg         <= 1'b0;
      carry_q     <= 1'b0;
      o_result_32 <= '0;
    end else begin
      case (state)
        IDLE: if (i_opValid_1) begin
          op_q  <= op_t'(i_mulOp_2);
          mcand <= rs1_abs;
          prod  <= {{XLEN{1'b0}}, rs2_abs};
          neg   <= rs1_neg ^ rs2_neg;
          cnt   <= '0;
        end
        CALC: begin
          prod <= {add_cout, add_sum, prod[XLEN-1:1]};
          cnt  <= incr(cnt);
        end
        NEG_LO: if (neg) begin
          prod[XLEN-1:0] <= add_sum;
          carry_q        <= add_cout;
        end
        NEG_HI: begin
          prod[2*XLEN-1:XLEN] <= hi_final;
          // The low word was already fixed up in NEG_LO, so MUL can take it directly.
          o_result_32 <= (op_q == OP_MUL) ? prod[XLEN-1:0] : hi_final;
        end
        default: ;
      endcase
    end
  end

  assign o_opReady_1     = (state == IDLE);
  assign o_busy_1        = (state != IDLE);
  assign o_resultValid_1 = (state == DONE);

endmodule

// File: tb/tb_m_seq_multiplier.sv
// Directed bench for m_seq_multiplier: products, fixed latency, backpressure and async reset.

module tb_m_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  mul_op;
  logic [31:0] opa, opb;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

  always #5 clk = ~clk;

  m_seq_multiplier dut (
    .i_clk_1         (clk),
    .i_rst_1         (rst),
    .i_opValid_1     (op_valid),
    .o_opReady_1     (op_ready),
    .i_mulOp_2       (mul_op),
    .i_operand1_32   (opa),
    .i_operand2_32   (opb),
    .o_resultValid_1 (res_valid),
    .i_resultReady_1 (res_ready),
    .o_result_32     (result),
    .o_busy_1        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure latency, hold the result for hold cycles, then hand it off.
  // With keep_valid the request stays asserted and operands are scrambled while busy.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int hold, input bit keep_valid);
    int   lat;
    logic rdy_seen;
    @(negedge clk);
    op_valid = 1'b1; mul_op = op; opa = a; opb = b;
    @(posedge clk); #1;
    if (keep_valid) begin
      mul_op = ~op; opa = ~a; opb = b ^ 32'h5A5A_5A5A;
    end else begin
      op_valid = 1'b0;
    end
    lat = 0;
    rdy_seen = 1'b0;
    while (!res_valid && lat < 40) begin
      rdy_seen = rdy_seen | op_ready;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd34);
    check({tag, " opready low while busy"}, {31'b0, rdy_seen}, 32'd0);
    check({tag, " result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " held valid"}, {31'b0, res_valid}, 32'd1);
      check({tag, " held result"}, result, exp);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    op_valid  = 1'b0;
    check({tag, " valid dropped"}, {31'b0, res_valid}, 32'd0);
    check({tag, " opready after handoff"}, {31'b0, op_ready}, 32'd1);
    check({tag, " result retained"}, result, exp);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
    mul_op = MUL; opa = '0; opb = '0;
    #12;
    check("reset opready", {31'b0, op_ready}, 32'd1);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset valid", {31'b0, res_valid}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul 7x6",         MUL,    32'd7,        32'd6,        32'h0000_002A, 0, 1'b0);
    run_op("mulhu ff*ff",     MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0);
    run_op("mul ff*ff",       MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
    run_op("mulh -1*-1",      MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0);
    run_op("mulh min*min",    MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 1'b0);
    run_op("mulhsu -1*ff",    MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("mulh min*1",      MULH,   32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("mulh 0*min",      MULH,   32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 0, 1'b0);
    run_op("mulhu min*2",     MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 0, 1'b0);
    run_op("mulh -2*3",       MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("mul -1*2",        MUL,    32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 0, 1'b0);
    run_op("mulhsu 2*min",    MULHSU, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 0, 1'b0);
    run_op("mulhu 12345678*9abcdef0", MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 0, 1'b0);

    // Backpressure with the request held high and operands disturbed while busy.
    run_op("backpressure",    MUL,    32'd1000,     32'd1000,     32'h000F_4240, 5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("single op only: busy", {31'b0, busy}, 32'd0);
    check("single op only: valid", {31'b0, res_valid}, 32'd0);

    // Reset asserted between edges partway through CALC.
    @(negedge clk);
    op_valid = 1'b1; mul_op = MUL; opa = 32'd9; opb = 32'd9;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset opready", {31'b0, op_ready}, 32'd1);
    check("midreset busy", {31'b0, busy}, 32'd0);
    check("midreset valid", {31'b0, res_valid}, 32'd0);
    check("midreset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("mul 3x5 after reset", MUL, 32'd3, 32'd5, 32'h0000_000F, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
